// File: rtl/if_id_hazard_ctrl_if.sv
// ----------------------------------------------------------------------------
// if_id_hazard_ctrl_if
//   Bundles the hazard inputs and the IF/ID / ID/EX sequencing controls that
//   pass between the pipeline datapath and the IF/ID hazard controller.
//
//   master : pipeline side (drives hazard inputs, consumes enables)
//   slave  : controller side (consumes hazard inputs, drives enables)
//
//   Signals
//     id_instr     instruction in IF/ID; rs=[10:8], rt=[7:5]
//     id_uses_rs   ID instruction reads rs
//     id_uses_rt   ID instruction reads rt
//     ex_mem_read  instruction in ID/EX is a load
//     ex_rd        destination register of the ID/EX instruction
//     br_taken     EX resolved a taken branch/jump this cycle
//     imem_stall   instruction memory not ready
//     dmem_stall   data memory busy, whole pipe freezes
//     halt_in      HALT decoded in ID
//     pc_en        PC write enable
//     if_id_en     IF/ID write enable
//     if_id_nop    IF/ID d-input selects nop_instr
//     nop_instr    NOP encoding
//     id_ex_bubble ID/EX loads a bubble
//     halted       core halted (registered)
//     stall_cnt    load-use / imem stall cycles   (HAZARD_PERF_CNT_EN only)
//     flush_cnt    redirect NOP-fill cycles       (HAZARD_PERF_CNT_EN only)
// ----------------------------------------------------------------------------
interface if_id_hazard_ctrl_if;
   logic [15:0] id_instr;
   logic        id_uses_rs;
   logic        id_uses_rt;
   logic        ex_mem_read;
   logic [2:0]  ex_rd;
   logic        br_taken;
   logic        imem_stall;
   logic        dmem_stall;
   logic        halt_in;

   logic        pc_en;
   logic        if_id_en;
   logic        if_id_nop;
   logic [15:0] nop_instr;
   logic        id_ex_bubble;
   logic        halted;
`ifdef HAZARD_PERF_CNT_EN
   logic [15:0] stall_cnt;
   logic [15:0] flush_cnt;
`endif

   modport master (
      output id_instr, id_uses_rs, id_uses_rt, ex_mem_read, ex_rd,
             br_taken, imem_stall, dmem_stall, halt_in,
      input  pc_en, if_id_en, if_id_nop, nop_instr, id_ex_bubble, halted
`ifdef HAZARD_PERF_CNT_EN
      , input stall_cnt, flush_cnt
`endif
   );

   modport slave (
      input  id_instr, id_uses_rs, id_uses_rt, ex_mem_read, ex_rd,
             br_taken, imem_stall, dmem_stall, halt_in,
      output pc_en, if_id_en, if_id_nop, nop_instr, id_ex_bubble, halted
`ifdef HAZARD_PERF_CNT_EN
      , output stall_cnt, flush_cnt
`endif
   );
endinterface

// File: rtl/if_id_hazard_ctrl.sv
// ----------------------------------------------------------------------------
// if_id_hazard_ctrl
//   Sequencing controller for the IF/ID register of the 16-bit pipelined core.
//   Each cycle decides whether PC and IF/ID advance, hold or take a NOP, and
//   whether ID/EX takes a bubble. Resolves load-use hazards, EX redirects,
//   instruction/data memory stalls and HALT, and keeps IF/ID NOP-filled for
//   FLUSH_EXTRA cycles after a redirect to cover fetch latency.
//
//   Ports
//     clk  system clock
//     rst  synchronous active-high reset
//     hz   controller side of if_id_hazard_ctrl_if (see interface header)
//
//   Parameters
//     NOP_INSTR    encoding loaded into IF/ID on flush
//     FLUSH_EXTRA  extra NOP-fill cycles after a redirect (0..7)
//
//   Optional feature macro: HAZARD_PERF_CNT_EN
//     Adds saturating stall_cnt / flush_cnt performance counters.
// ----------------------------------------------------------------------------
module if_id_hazard_ctrl #(
   parameter logic [15:0] NOP_INSTR   = 16'h0800,
   parameter int unsigned FLUSH_EXTRA = 0
) (
   input logic                  clk,
   input logic                  rst,
   if_id_hazard_ctrl_if.slave   hz
);

   typedef enum logic [1:0] {StRun, StFlush, StHalted} state_e;

   localparam logic [2:0] FlushInit = 3'(FLUSH_EXTRA);

   state_e     st_q, st_d;
   logic [2:0] fcnt_q, fcnt_d;
   logic       halted_q, halted_d;

   logic       load_use;
   logic       stall_win;   // load-use or imem stall won arbitration
   logic       flush_win;   // NOP-fill caused by redirect or flush window

   // Only the rs/rt fields of the ID instruction matter here.
   logic       unused_instr;
   assign unused_instr = ^{hz.id_instr[15:11], hz.id_instr[4:0]};

   assign load_use = hz.ex_mem_read &
                     ((hz.id_uses_rs & (hz.ex_rd == hz.id_instr[10:8])) |
                      (hz.id_uses_rt & (hz.ex_rd == hz.id_instr[7:5])));

   assign hz.nop_instr = NOP_INSTR;
   assign hz.halted    = halted_q;

   always_comb begin
      st_d            = st_q;
      fcnt_d          = fcnt_q;
      halted_d        = halted_q;
      hz.pc_en        = 1'b1;
      hz.if_id_en     = 1'b1;
      hz.if_id_nop    = 1'b0;
      hz.id_ex_bubble = 1'b0;
      stall_win       = 1'b0;
      flush_win       = 1'b0;

      if (rst) begin
         // Fill both pipeline registers with NOPs while held in reset.
         hz.pc_en        = 1'b0;
         hz.if_id_nop    = 1'b1;
         hz.id_ex_bubble = 1'b1;
         st_d            = StRun;
         fcnt_d          = 3'd0;
         halted_d        = 1'b0;
      end else if (st_q == StHalted) begin
         hz.pc_en        = 1'b0;
         hz.if_id_en     = 1'b0;
         hz.id_ex_bubble = 1'b1;
         halted_d        = 1'b1;
      end else if (hz.dmem_stall) begin
         // Full freeze; a concurrent redirect is re-presented by EX afterwards.
         hz.pc_en    = 1'b0;
         hz.if_id_en = 1'b0;
      end else if (hz.br_taken) begin
         hz.if_id_nop    = 1'b1;
         hz.id_ex_bubble = 1'b1;
         flush_win       = 1'b1;
         if (FLUSH_EXTRA != 0) begin
            st_d   = StFlush;
            fcnt_d = FlushInit;
         end else begin
            st_d   = StRun;
            fcnt_d = 3'd0;
         end
      end else if (st_q == StFlush) begin
         // ID holds a NOP here, so load-use and HALT cannot originate from it.
         hz.pc_en     = ~hz.imem_stall;
         hz.if_id_nop = 1'b1;
         flush_win    = 1'b1;
         if (!hz.imem_stall) begin
            fcnt_d = fcnt_q - 3'd1;
            if (fcnt_q <= 3'd1) begin
               st_d   = StRun;
               fcnt_d = 3'd0;
            end
         end
      end else if (load_use) begin
         hz.pc_en        = 1'b0;
         hz.if_id_en     = 1'b0;
         hz.id_ex_bubble = 1'b1;
         stall_win       = 1'b1;
      end else if (hz.imem_stall) begin
         hz.pc_en     = 1'b0;
         hz.if_id_nop = 1'b1;
         stall_win    = 1'b1;
      end else if (hz.halt_in) begin
         hz.pc_en        = 1'b0;
         hz.if_id_en     = 1'b0;
         hz.id_ex_bubble = 1'b1;
         st_d            = StHalted;
         halted_d        = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         st_q     <= StRun;
         fcnt_q   <= 3'd0;
         halted_q <= 1'b0;
      end else begin
         st_q     <= st_d;
         fcnt_q   <= fcnt_d;
         halted_q <= halted_d;
      end
   end

`ifdef HAZARD_PERF_CNT_EN
   logic [15:0] stall_cnt_q, stall_cnt_d;
   logic [15:0] flush_cnt_q, flush_cnt_d;

   // Halted and dmem_stall cycles never raise a win flag, so counters freeze.
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (stall_win && (stall_cnt_q != 16'hFFFF)) stall_cnt_d = stall_cnt_q + 16'd1;
      if (flush_win && (flush_cnt_q != 16'hFFFF)) flush_cnt_d = flush_cnt_q + 16'd1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt_q <= 16'd0;
         flush_cnt_q <= 16'd0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign hz.stall_cnt = stall_cnt_q;
   assign hz.flush_cnt = flush_cnt_q;
`else
   logic unused_win;
   assign unused_win = stall_win ^ flush_win;
`endif

endmodule

// File: tb/tb_if_id_hazard_ctrl.sv
// ----------------------------------------------------------------------------
// tb_if_id_hazard_ctrl
//   Self-checking bench for if_id_hazard_ctrl (FLUSH_EXTRA = 2): a table of
//   single-cycle vectors, hand-written multi-cycle sequences and randomized
//   stimulus against a behavioural model.
// ----------------------------------------------------------------------------
module tb_if_id_hazard_ctrl;

   localparam int unsigned FE  = 2;
   localparam logic [15:0] NOP = 16'h0800;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   if_id_hazard_ctrl_if bus ();

   if_id_hazard_ctrl #(
      .NOP_INSTR  (NOP),
      .FLUSH_EXTRA(FE)
   ) dut (
      .clk(clk),
      .rst(rst),
      .hz (bus.slave)
   );

   int checks   = 0;
   int failures = 0;

   // Behavioural model state: remaining NOP-fill cycles after a redirect.
   int m_flush_left;
   bit m_halted;
   int m_stall_cnt, m_flush_cnt;
   int n_flush_left;
   bit n_halted;
   int n_stall_cnt, n_flush_cnt;

   typedef struct {
      logic        rst;
      logic [15:0] instr;
      logic        rs;
      logic        rt;
      logic        mrd;
      logic [2:0]  rd;
      logic        br;
      logic        imem;
      logic        dmem;
      logic        halt;
      logic [3:0]  exp;  // {pc_en, if_id_en, if_id_nop, id_ex_bubble}
   } vec_t;

   vec_t vecs[12];

   task automatic idle();
      bus.id_instr    = 16'h0000;
      bus.id_uses_rs  = 1'b0;
      bus.id_uses_rt  = 1'b0;
      bus.ex_mem_read = 1'b0;
      bus.ex_rd       = 3'd0;
      bus.br_taken    = 1'b0;
      bus.imem_stall  = 1'b0;
      bus.dmem_stall  = 1'b0;
      bus.halt_in     = 1'b0;
      rst             = 1'b0;
   endtask

   // Returns {pc_en, if_id_en, if_id_nop, id_ex_bubble, halted}; fills n_*.
   function automatic logic [4:0] model_eval();
      logic [3:0] o;
      bit lu;
      lu = bus.ex_mem_read &&
           ((bus.id_uses_rs && bus.ex_rd == bus.id_instr[10:8]) ||
            (bus.id_uses_rt && bus.ex_rd == bus.id_instr[7:5]));
      n_flush_left = m_flush_left;
      n_halted     = m_halted;
      n_stall_cnt  = m_stall_cnt;
      n_flush_cnt  = m_flush_cnt;
      if (rst) begin
         o = 4'b0111;
         n_flush_left = 0; n_halted = 0; n_stall_cnt = 0; n_flush_cnt = 0;
      end else if (m_halted) begin
         o = 4'b0001;
      end else if (bus.dmem_stall) begin
         o = 4'b0000;
      end else if (bus.br_taken) begin
         o = 4'b1111;
         n_flush_left = FE;
         n_flush_cnt  = (m_flush_cnt < 65535) ? m_flush_cnt + 1 : m_flush_cnt;
      end else if (m_flush_left > 0) begin
         o = {~bus.imem_stall, 3'b110};
         if (!bus.imem_stall) n_flush_left = m_flush_left - 1;
         n_flush_cnt = (m_flush_cnt < 65535) ? m_flush_cnt + 1 : m_flush_cnt;
      end else if (lu) begin
         o = 4'b0001;
         n_stall_cnt = (m_stall_cnt < 65535) ? m_stall_cnt + 1 : m_stall_cnt;
      end else if (bus.imem_stall) begin
         o = 4'b0110;
         n_stall_cnt = (m_stall_cnt < 65535) ? m_stall_cnt + 1 : m_stall_cnt;
      end else if (bus.halt_in) begin
         o = 4'b0001;
         n_halted = 1;
      end else begin
         o = 4'b1100;
      end
      return {o, m_halted};
   endfunction

   // One clock: compare mid-cycle, then advance the model at the edge.
   task automatic step(input string name, input bit has_exp, input logic [3:0] exp4);
      logic [4:0] mexp;
      logic [4:0] act;
      #3;
      mexp = model_eval();
      act  = {bus.pc_en, bus.if_id_en, bus.if_id_nop, bus.id_ex_bubble, bus.halted};
      checks++;
      if (act !== mexp) begin
         failures++;
         $display("FAIL %s model: got {pc,ifid,nop,bub,halt}=%b want %b at %0t",
                  name, act, mexp, $time);
      end
      if (has_exp) begin
         checks++;
         if (act[4:1] !== exp4) begin
            failures++;
            $display("FAIL %s fixed: got {pc,ifid,nop,bub}=%b want %b at %0t",
                     name, act[4:1], exp4, $time);
         end
      end
`ifdef HAZARD_PERF_CNT_EN
      checks++;
      if (bus.stall_cnt !== 16'(m_stall_cnt) || bus.flush_cnt !== 16'(m_flush_cnt)) begin
         failures++;
         $display("FAIL %s counters: got stall=%0d flush=%0d want stall=%0d flush=%0d",
                  name, bus.stall_cnt, bus.flush_cnt, m_stall_cnt, m_flush_cnt);
      end
`endif
      @(posedge clk);
      m_flush_left = n_flush_left;
      m_halted     = n_halted;
      m_stall_cnt  = n_stall_cnt;
      m_flush_cnt  = n_flush_cnt;
      #1;
   endtask

   task automatic set_lu(input bit on);
      bus.id_instr    = 16'h0300;  // rs = 3
      bus.id_uses_rs  = 1'b1;
      bus.ex_rd       = 3'd3;
      bus.ex_mem_read = on;
   endtask

   initial begin
      //            rst instr    rs  rt  mrd rd    br  imem dmem halt exp
      vecs[0]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1100};
      vecs[1]  = '{1'b0, 16'h0300, 1'b1, 1'b0, 1'b1, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0001};
      vecs[2]  = '{1'b0, 16'h0300, 1'b0, 1'b0, 1'b1, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1100};
      vecs[3]  = '{1'b0, 16'h00A0, 1'b0, 1'b1, 1'b1, 3'd5, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0001};
      vecs[4]  = '{1'b0, 16'h00A0, 1'b1, 1'b1, 1'b0, 3'd5, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1100};
      vecs[5]  = '{1'b0, 16'h0300, 1'b1, 1'b0, 1'b1, 3'd3, 1'b1, 1'b0, 1'b0, 1'b0, 4'b1111};
      vecs[6]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0000};
      vecs[7]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0110};
      vecs[8]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0001};
      vecs[9]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b1, 4'b0110};
      vecs[10] = '{1'b0, 16'h0300, 1'b1, 1'b0, 1'b1, 3'd3, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0001};
      vecs[11] = '{1'b1, 16'h0300, 1'b1, 1'b0, 1'b1, 3'd3, 1'b1, 1'b1, 1'b0, 1'b1, 4'b0111};

      idle();
      rst = 1'b1;
      @(posedge clk);
      #1;
      m_flush_left = 0; m_halted = 0; m_stall_cnt = 0; m_flush_cnt = 0;

      // Reset held two cycles, then first free-running cycle.
      step("reset_c1", 1, 4'b0111);
      step("reset_c2", 1, 4'b0111);
      rst = 1'b0;
      step("post_reset", 1, 4'b1100);
      checks++;
      if (bus.nop_instr !== NOP) begin
         failures++;
         $display("FAIL nop_instr: got %h want %h", bus.nop_instr, NOP);
      end

      // Single-cycle vectors, each from a fresh RUN state.
      for (int i = 0; i < 12; i++) begin
         idle();
         rst = 1'b1;
         step("vec_reset", 0, 4'b0000);
         bus.id_instr    = vecs[i].instr;
         bus.id_uses_rs  = vecs[i].rs;
         bus.id_uses_rt  = vecs[i].rt;
         bus.ex_mem_read = vecs[i].mrd;
         bus.ex_rd       = vecs[i].rd;
         bus.br_taken    = vecs[i].br;
         bus.imem_stall  = vecs[i].imem;
         bus.dmem_stall  = vecs[i].dmem;
         bus.halt_in     = vecs[i].halt;
         rst             = vecs[i].rst;
         step($sformatf("vec%0d", i), 1, vecs[i].exp);
      end

      // Load-use lasts one cycle: the bubble clears ex_mem_read next cycle.
      idle(); rst = 1'b1; step("lu_reset", 0, 4'b0000); rst = 1'b0;
      set_lu(1'b1);
      step("lu_stall", 1, 4'b0001);
      set_lu(1'b0);
      step("lu_resume", 1, 4'b1100);

      // Redirect: three NOP cycles with the PC advancing.
      idle();
      bus.br_taken = 1'b1; step("br_c0", 1, 4'b1111);
      bus.br_taken = 1'b0; step("br_c1", 1, 4'b1110);
      step("br_c2", 1, 4'b1110);
      step("br_c3", 1, 4'b1100);

      // Redirect with imem stall in the 2nd cycle: window stretches to four.
      bus.br_taken = 1'b1; step("bri_c0", 1, 4'b1111);
      bus.br_taken = 1'b0; bus.imem_stall = 1'b1; step("bri_c1", 1, 4'b0110);
      bus.imem_stall = 1'b0; step("bri_c2", 1, 4'b1110);
      step("bri_c3", 1, 4'b1110);
      step("bri_c4", 1, 4'b1100);

      // Redirect during the flush window restarts the count.
      bus.br_taken = 1'b1; step("brr_c0", 1, 4'b1111);
      bus.br_taken = 1'b0; step("brr_c1", 1, 4'b1110);
      bus.br_taken = 1'b1; step("brr_c2", 1, 4'b1111);
      bus.br_taken = 1'b0; step("brr_c3", 1, 4'b1110);
      step("brr_c4", 1, 4'b1110);
      step("brr_c5", 1, 4'b1100);

      // HALT: sticky across redirects until reset.
      bus.halt_in = 1'b1; step("halt_enter", 1, 4'b0001);
      bus.halt_in = 1'b0;
      for (int i = 0; i < 10; i++) begin
         bus.br_taken = i[0];
         step("halted_hold", 1, 4'b0001);
      end
      idle(); rst = 1'b1; step("halt_rst", 1, 4'b0111);
      rst = 1'b0; step("halt_exit", 1, 4'b1100);

`ifdef HAZARD_PERF_CNT_EN
      // Three load-use stalls plus one redirect (FE=2 gives three fill cycles).
      idle(); rst = 1'b1; step("perf_rst", 0, 4'b0000); rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         set_lu(1'b1); step("perf_lu", 1, 4'b0001);
         set_lu(1'b0); step("perf_run", 1, 4'b1100);
      end
      bus.br_taken = 1'b1; step("perf_br", 0, 4'b0000);
      bus.br_taken = 1'b0;
      for (int i = 0; i < 3; i++) step("perf_fl", 0, 4'b0000);
      checks++;
      if (bus.stall_cnt !== 16'd3 || bus.flush_cnt !== 16'd3) begin
         failures++;
         $display("FAIL perf_totals: got stall=%0d flush=%0d want stall=3 flush=3",
                  bus.stall_cnt, bus.flush_cnt);
      end
`endif

      // Randomized traffic against the model.
      for (int i = 0; i < 3000; i++) begin
         bus.id_instr    = 16'($urandom);
         bus.id_uses_rs  = 1'($urandom_range(0, 1));
         bus.id_uses_rt  = 1'($urandom_range(0, 1));
         bus.ex_mem_read = 1'($urandom_range(0, 1));
         bus.ex_rd       = ($urandom_range(0, 1) == 1) ? bus.id_instr[10:8]
                                                       : 3'($urandom);
         bus.br_taken    = ($urandom_range(0, 7) == 0);
         bus.imem_stall  = ($urandom_range(0, 5) == 0);
         bus.dmem_stall  = ($urandom_range(0, 7) == 0);
         bus.halt_in     = ($urandom_range(0, 31) == 0);
         rst             = ($urandom_range(0, 39) == 0);
         step("rand", 0, 4'b0000);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
